multicycle_control: RTL and testbench

Multi-cycle main control FSM for the RV32I subset datapath: lb, sb, add, and, sll, ori, bne. It decodes the fetched instruction and drives every datapath enable and mux select. It produces the 4-bit ALUControl code that the ALU consumes, and reads back the ALU zero flag to resolve branches. It sits between the instruction register and the datapath, and stalls on a memory-ready handshake.

---
 rtl/control_pkg.sv | 69 ++++++
 rtl/multicycle_control_alu_dec.sv | 41 ++++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multicycle RV32I control path and its ALU.
package control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        RST      = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Which ALU operation a state asks for; AC_FUNCT defers to funct3/funct7.
    typedef enum logic [2:0] {
        AC_NONE  = 3'd0,
        AC_ADD   = 3'd1,
        AC_FUNCT = 3'd2,
        AC_OR    = 3'd3,
        AC_BNE   = 3'd4
    } alu_class_t;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_SB  = 3'b000;
    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_AND = 3'b111;
    localparam logic [F3_W-1:0] F3_SLL = 3'b001;
    localparam logic [F3_W-1:0] F3_ORI = 3'b110;
    localparam logic [F3_W-1:0] F3_BNE = 3'b001;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_BNE = 4'b0110;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_REGA  = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REGB = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MDR       = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_dec.sv
// Combinational ALUControl map plus R-type legality check.
module alu_op_decoder
    import control_pkg::*;
(
    input  alu_class_t        alu_class,
    input  logic [F3_W-1:0]   funct3,
    input  logic [F7_W-1:0]   funct7,
    output logic [ALU_W-1:0]  alu_control_c,
    output logic              rtype_legal_c
);

    // Supported R-type ops need funct7 = 0 and one of add/and/sll.
    always_comb begin
        rtype_legal_c = 1'b0;
        if (funct7 == F7_BASE) begin
            case (funct3)
                F3_ADD, F3_AND, F3_SLL: rtype_legal_c = 1'b1;
                default:                rtype_legal_c = 1'b0;
            endcase
        end
    end

    // Operation select; idle states drive 0000.
    always_comb begin
        alu_control_c = ALU_W'(0);
        case (alu_class)
            AC_ADD: alu_control_c = ALU_ADD;
            AC_OR:  alu_control_c = ALU_OR;
            AC_BNE: alu_control_c = ALU_BNE;
            AC_FUNCT: begin
                case (funct3)
                    F3_AND:  alu_control_c = ALU_AND;
                    F3_SLL:  alu_control_c = ALU_SLL;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            default: alu_control_c = ALU_W'(0);
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: decodes lb/sb/add/and/sll/ori/bne and drives the datapath.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [F3_W-1:0]      funct3,
    input  logic [F7_W-1:0]      funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [SEL_W-1:0]     ALUSrcA,
    output logic [SEL_W-1:0]     ALUSrcB,
    output logic [SEL_W-1:0]     ResultSrc,
    output logic [ALU_W-1:0]     ALUControl,
    output logic                 illegal,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retired_count
);

    state_t     state_q;
    state_t     state_d;
    alu_class_t alu_class;
    logic       rtype_legal;

    alu_op_decoder u_alu_dec (
        .alu_class     (alu_class),
        .funct3        (funct3),
        .funct7        (funct7),
        .alu_control_c (ALUControl),
        .rtype_legal_c (rtype_legal)
    );

    // State register; async reset lands in RST so outputs drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RST;
        else        state_q <= state_d;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_count <= CNT_WIDTH'(0);
        else if (retire) retired_count <= retired_count + CNT_WIDTH'(1);
    end

    // Next-state and Moore outputs (plus zero/mem_ready qualified enables).
    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_REGB;
        ResultSrc = RES_ALUOUT;
        alu_class = AC_NONE;
        illegal   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            RST: state_d = FETCH;

            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                alu_class = AC_ADD;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end

            DECODE: begin
                // Branch target into ALUOut while the opcode is classified.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_IMM;
                alu_class = AC_ADD;
                case (opcode)
                    OP_LOAD:   state_d = (funct3 == F3_LB)  ? MEMADR : TRAP;
                    OP_STORE:  state_d = (funct3 == F3_SB)  ? MEMADR : TRAP;
                    OP_RTYPE:  state_d = rtype_legal        ? EXECR  : TRAP;
                    OP_IMM:    state_d = (funct3 == F3_ORI) ? EXECI  : TRAP;
                    OP_BRANCH: state_d = (funct3 == F3_BNE) ? BRANCH : TRAP;
                    default:   state_d = TRAP;
                endcase
            end

            MEMADR: begin
                ALUSrcA   = SRCA_REGA;
                ALUSrcB   = SRCB_IMM;
                alu_class = AC_ADD;
                state_d   = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end

            MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end

            MEMWB: begin
                ResultSrc = RES_MDR;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = mem_ready;
                if (mem_ready) state_d = FETCH;
            end

            EXECR: begin
                ALUSrcA   = SRCA_REGA;
                ALUSrcB   = SRCB_REGB;
                alu_class = AC_FUNCT;
                state_d   = ALUWB;
            end

            EXECI: begin
                ALUSrcA   = SRCA_REGA;
                ALUSrcB   = SRCB_IMM;
                alu_class = AC_OR;
                state_d   = ALUWB;
            end

            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            BRANCH: begin
                // bne-compare gives 0 when operands differ, so zero=1 is taken.
                ALUSrcA   = SRCA_REGA;
                ALUSrcB   = SRCB_REGB;
                alu_class = AC_BNE;
                ResultSrc = RES_ALUOUT;
                PCWrite   = zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end

            TRAP: illegal = 1'b1;

            default: state_d = RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued by stimulus, checked by a monitor.
module tb_multicycle_control;

    localparam int unsigned CW = 3;

    typedef enum int {S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
                      S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_TRAP} tst_t;

    typedef struct packed {
        logic          pcw;
        logic          adr;
        logic          mrd;
        logic          mwr;
        logic          irw;
        logic          rgw;
        logic [1:0]    srca;
        logic [1:0]    srcb;
        logic [1:0]    res;
        logic [3:0]    alu;
        logic          ill;
        logic          ret;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]    ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]    ALUControl;
    logic          illegal, retire;
    logic [CW-1:0] retired_count;

    exp_t          exp_q[$];
    string         name_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            checks = 0;
    int            errors = 0;
    exp_t          mon_e, mon_a;
    string         mon_nm;

    multicycle_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .illegal(illegal), .retire(retire), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Expected outputs for one state, taken from the control table.
    function automatic exp_t ex(input tst_t s, input logic rdy, input logic z, input logic [3:0] alu);
        exp_t e = '0;
        case (s)
            S_FETCH:    begin e.mrd = 1; e.srcb = 2'b10; e.alu = 4'b0010; e.res = 2'b10;
                              e.irw = rdy; e.pcw = rdy; end
            S_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; e.alu = 4'b0010; end
            S_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = 4'b0010; end
            S_MEMREAD:  begin e.adr = 1; e.mrd = 1; end
            S_MEMWB:    begin e.res = 2'b01; e.rgw = 1; e.ret = 1; end
            S_MEMWRITE: begin e.adr = 1; e.mwr = 1; e.ret = rdy; end
            S_EXECR:    begin e.srca = 2'b10; e.srcb = 2'b00; e.alu = alu; end
            S_EXECI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = 4'b0001; end
            S_ALUWB:    begin e.rgw = 1; e.ret = 1; end
            S_BRANCH:   begin e.srca = 2'b10; e.alu = 4'b0110; e.pcw = z; e.ret = 1; end
            S_TRAP:     e.ill = 1;
            default:    e = '0;
        endcase
        return e;
    endfunction

    // Drive one cycle of inputs, queue what the DUT must show this cycle.
    task automatic cyc(input tst_t s, input string nm, input logic rdy = 1'b1,
                       input logic z = 1'b0, input logic [3:0] alu = 4'b0010);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        e         = ex(s, rdy, z, alu);
        e.cnt     = exp_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (e.ret) exp_cnt = exp_cnt + CW'(1);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic rtype(input string nm, input logic [2:0] f3, input logic [3:0] alu);
        instr(7'b0110011, f3, 7'b0000000);
        cyc(S_FETCH, {nm, "_fetch"});
        cyc(S_DECODE, {nm, "_decode"});
        cyc(S_EXECR, {nm, "_execr"}, 1'b1, 1'b0, alu);
        cyc(S_ALUWB, {nm, "_aluwb"});
    endtask

    task automatic bne(input string nm, input logic z);
        instr(7'b1100011, 3'b001, 7'b0000000);
        cyc(S_FETCH, {nm, "_fetch"});
        cyc(S_DECODE, {nm, "_decode"});
        cyc(S_BRANCH, {nm, "_branch"}, 1'b1, z);
    endtask

    // Monitor: one queued expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            mon_a  = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                      ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal, retire, retired_count};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", mon_nm, mon_a, mon_e);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc(S_RST, "reset_hold");
        rst_n = 1'b1;
        cyc(S_RST, "rst_state");

        rtype("add", 3'b000, 4'b0010);

        // lb with one fetch wait and three memory wait cycles
        instr(7'b0000011, 3'b000, 7'b0000000);
        cyc(S_FETCH, "lb_fetch_wait", 1'b0);
        cyc(S_FETCH, "lb_fetch");
        cyc(S_DECODE, "lb_decode");
        cyc(S_MEMADR, "lb_memadr");
        repeat (3) cyc(S_MEMREAD, "lb_memread_wait", 1'b0);
        cyc(S_MEMREAD, "lb_memread_done");
        cyc(S_MEMWB, "lb_memwb");

        // sb with one write wait cycle
        instr(7'b0100011, 3'b000, 7'b0000000);
        cyc(S_FETCH, "sb_fetch");
        cyc(S_DECODE, "sb_decode");
        cyc(S_MEMADR, "sb_memadr");
        cyc(S_MEMWRITE, "sb_memwrite_wait", 1'b0);
        cyc(S_MEMWRITE, "sb_memwrite_done");

        bne("bne_taken", 1'b1);
        bne("bne_not_taken", 1'b0);
        rtype("sll", 3'b001, 4'b1000);
        rtype("and", 3'b111, 4'b0000);

        // ori retires the 8th instruction: 3-bit counter wraps to 0
        instr(7'b0010011, 3'b110, 7'b0000000);
        cyc(S_FETCH, "ori_fetch");
        cyc(S_DECODE, "ori_decode");
        cyc(S_EXECI, "ori_execi");
        cyc(S_ALUWB, "ori_aluwb");
        rtype("add_after_wrap", 3'b000, 4'b0010);

        // reset in the middle of a stalled load
        instr(7'b0000011, 3'b000, 7'b0000000);
        cyc(S_FETCH, "lb2_fetch");
        cyc(S_DECODE, "lb2_decode");
        cyc(S_MEMADR, "lb2_memadr");
        cyc(S_MEMREAD, "lb2_memread_wait", 1'b0);
        rst_n   = 1'b0;
        exp_cnt = '0;
        cyc(S_RST, "reset_mid_memread", 1'b0);
        rst_n = 1'b1;
        cyc(S_RST, "rst_after_abort");
        cyc(S_FETCH, "fetch_after_abort");
        cyc(S_DECODE, "decode_after_abort");
        cyc(S_MEMADR, "memadr_after_abort");
        cyc(S_MEMREAD, "memread_after_abort");
        cyc(S_MEMWB, "memwb_after_abort");

        // unsupported opcode (jal) traps until reset
        instr(7'b1101111, 3'b000, 7'b0000000);
        cyc(S_FETCH, "jal_fetch");
        cyc(S_DECODE, "jal_decode");
        for (int i = 0; i < 20; i++) cyc(S_TRAP, "jal_trap", i[0], ~i[0]);
        rst_n   = 1'b0;
        exp_cnt = '0;
        cyc(S_RST, "trap_reset");
        rst_n = 1'b1;
        cyc(S_RST, "trap_cleared");

        // R-type with nonzero funct7 (sub) is illegal
        instr(7'b0110011, 3'b000, 7'b0100000);
        cyc(S_FETCH, "sub_fetch");
        cyc(S_DECODE, "sub_decode");
        repeat (3) cyc(S_TRAP, "sub_trap");
        rst_n = 1'b0;
        cyc(S_RST, "sub_reset");
        rst_n = 1'b1;
        cyc(S_RST, "sub_cleared");
        instr(7'b0110011, 3'b000, 7'b0000000);
        cyc(S_FETCH, "fetch_after_trap");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
